// File: rtl/instr_mem_stim_gen.sv
// ---------------------------------------------------------------------------
// instr_mem_stim_gen
//
// Purpose: behavioural-but-synthesizable instruction memory stand-in that
// answers fetch requests with a NOP stream during a flush phase after reset,
// then with pseudo-random LUI/ADDI instructions. Grants can be throttled by
// an LFSR, and responses come back in order after a fixed or random latency.
//
// Ports:
//   clk_i            sole clock, rising edge
//   rst_ni           asynchronous active-low reset
//   instr_req_i      fetch request
//   instr_addr_i     fetch byte address (bits [1:0] ignored)
//   instr_gnt_o      request accepted this cycle
//   instr_rvalid_o   response valid
//   instr_rdata_o    instruction word (0 when no response)
//   instr_err_o      bus error, qualified by instr_rvalid_o
//   phase2_active_o  random-instruction phase active
//   cycle_count_o    saturating cycles since reset release
// ---------------------------------------------------------------------------
module instr_mem_stim_gen #(
  parameter int unsigned FlushCycles    = 100,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StallMode      = 0,
  parameter int unsigned MaxStall       = 3,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned LatMode        = 0,
  parameter logic [31:0] Seed           = 32'hACE1_2025,
  parameter logic [31:0] MemBase        = 32'h0000_0000,
  parameter logic [31:0] MemSize        = 32'h0001_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  output logic        phase2_active_o,
  output logic [31:0] cycle_count_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  localparam logic [PtrW-1:0] PtrLast   = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] CntFull   = CntW'(MaxOutstanding);
  localparam logic [31:0]     Taps      = 32'h8020_0003;
  // An all-zero Galois LFSR never leaves zero, so a zero seed is bumped to 1.
  localparam logic [31:0]     SeedEff   = (Seed == 32'h0) ? 32'h1 : Seed;
  localparam logic [31:0]     FlushC    = 32'(FlushCycles);
  localparam logic [3:0]      RespLatC  = 4'(RespLatency);
  localparam logic [7:0]      MaxStallC = 8'(MaxStall);
  // Window bounds in 33 bits so MemBase + MemSize cannot wrap.
  localparam logic [32:0]     WinLo     = {1'b0, MemBase};
  localparam logic [32:0]     WinHi     = {1'b0, MemBase} + {1'b0, MemSize};
  localparam bit              RandStall = (StallMode != 0);
  localparam bit              RandLat   = (LatMode != 0);

  localparam logic [31:0] InstrNop = 32'h0000_0013;

  // free-running state
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        phase2_q, phase2_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;

  // response queue
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic        slot_vld_q  [MaxOutstanding];
  logic        slot_vld_d  [MaxOutstanding];
  logic [31:0] slot_data_q [MaxOutstanding];
  logic [31:0] slot_data_d [MaxOutstanding];
  logic        slot_err_q  [MaxOutstanding];
  logic        slot_err_d  [MaxOutstanding];
  // Remaining cycles until the entry is due; all entries count in parallel
  // from their own grant, so a non-head entry is released at the later of
  // its due cycle and the cycle after the previous response.
  logic [3:0]  slot_rem_q  [MaxOutstanding];
  logic [3:0]  slot_rem_d  [MaxOutstanding];

  logic        full;
  logic        grant_ok;
  logic        gnt;
  logic        accept;
  logic        pop;
  logic [31:0] addr_word;
  logic        in_win;
  logic [31:0] new_data;
  logic        new_err;
  logic [3:0]  new_rem;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^instr_addr_i[1:0];
  assign addr_word       = {instr_addr_i[31:2], 2'b00};
  assign in_win          = ({1'b0, addr_word} >= WinLo) && ({1'b0, addr_word} < WinHi);

  // Full compares the registered occupancy only: a pop in the same cycle
  // does not free a slot for a new grant until the next cycle.
  assign full     = (count_q == CntFull);
  assign grant_ok = RandStall ? (lfsr_q[0] || (stall_cnt_q == MaxStallC)) : 1'b1;
  // rst_ni gates the grant so it is forced low combinationally during reset.
  assign gnt      = rst_ni && instr_req_i && !full && grant_ok;
  assign accept   = gnt;
  assign pop      = slot_vld_q[rd_ptr_q] && (slot_rem_q[rd_ptr_q] == 4'd0);

  always_comb begin
    new_err  = !in_win;
    new_data = 32'h0;
    if (in_win) begin
      if (!phase2_q) begin
        new_data = InstrNop;
      end else if (!lfsr_q[1]) begin
        new_data = {lfsr_q[31:12], lfsr_q[11:7], 7'b0110111};
      end else begin
        new_data = {lfsr_q[31:20], lfsr_q[19:15], 3'b000, lfsr_q[11:7], 7'b0010011};
      end
    end
  end

  // Stored value is latency-1: an entry with latency 1 is due the cycle
  // right after its grant.
  always_comb begin
    if (RandLat) begin
      new_rem = lfsr_q[7:4] % RespLatC;
    end else begin
      new_rem = RespLatC - 4'd1;
    end
  end

  always_comb begin
    cycle_cnt_d = (cycle_cnt_q == 32'hFFFF_FFFF) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
    // Compared against the next count so the flag lines up with the count.
    phase2_d    = (cycle_cnt_d >= FlushC);
    lfsr_d      = lfsr_q[0] ? ((lfsr_q >> 1) ^ Taps) : (lfsr_q >> 1);

    stall_cnt_d = stall_cnt_q;
    if (!instr_req_i || accept) begin
      stall_cnt_d = 8'd0;
    end else if (!full && (stall_cnt_q != MaxStallC)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    end
    if (accept && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!accept && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < MaxOutstanding; i++) begin
      slot_vld_d[i]  = slot_vld_q[i];
      slot_data_d[i] = slot_data_q[i];
      slot_err_d[i]  = slot_err_q[i];
      slot_rem_d[i]  = slot_rem_q[i];
      if (slot_vld_q[i] && (slot_rem_q[i] != 4'd0)) begin
        slot_rem_d[i] = slot_rem_q[i] - 4'd1;
      end
      if (pop && (rd_ptr_q == PtrW'(i))) begin
        slot_vld_d[i] = 1'b0;
      end
      if (accept && (wr_ptr_q == PtrW'(i))) begin
        slot_vld_d[i]  = 1'b1;
        slot_data_d[i] = new_data;
        slot_err_d[i]  = new_err;
        slot_rem_d[i]  = new_rem;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_q <= 32'h0;
      phase2_q    <= 1'b0;
      lfsr_q      <= SeedEff;
      stall_cnt_q <= 8'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      phase2_q    <= phase2_d;
      lfsr_q      <= lfsr_d;
      stall_cnt_q <= stall_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        slot_vld_q[i]  <= 1'b0;
        slot_data_q[i] <= 32'h0;
        slot_err_q[i]  <= 1'b0;
        slot_rem_q[i]  <= 4'd0;
      end
    end else begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        slot_vld_q[i]  <= slot_vld_d[i];
        slot_data_q[i] <= slot_data_d[i];
        slot_err_q[i]  <= slot_err_d[i];
        slot_rem_q[i]  <= slot_rem_d[i];
      end
    end
  end

  assign instr_gnt_o     = gnt;
  assign instr_rvalid_o  = pop;
  assign instr_rdata_o   = pop ? slot_data_q[rd_ptr_q] : 32'h0;
  assign instr_err_o     = pop ? slot_err_q[rd_ptr_q] : 1'b0;
  assign phase2_active_o = phase2_q;
  assign cycle_count_o   = cycle_cnt_q;

endmodule

// File: tb/tb_instr_mem_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_stim_gen
//
// Four instances share clock and reset:
//   u0 default parameters
//   u1 FlushCycles=4 (random-instruction phase)
//   u2 MaxOutstanding=2, RespLatency=5 (back-pressure)
//   u3 StallMode=1, MaxStall=3 (randomised grants)
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge. Cycle n is the cycle in which cycle_count_o reads n.
// ---------------------------------------------------------------------------
module tb_instr_mem_stim_gen;

  localparam logic [31:0] SEED = 32'hACE1_2025;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req, gnt, rv, er, ph;
  logic [31:0] addr [4];
  logic [31:0] rd   [4];
  logic [31:0] cc   [4];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_mem_stim_gen u0 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req[0]), .instr_addr_i(addr[0]),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rv[0]), .instr_rdata_o(rd[0]),
    .instr_err_o(er[0]), .phase2_active_o(ph[0]), .cycle_count_o(cc[0]));

  instr_mem_stim_gen #(.FlushCycles(4)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req[1]), .instr_addr_i(addr[1]),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rv[1]), .instr_rdata_o(rd[1]),
    .instr_err_o(er[1]), .phase2_active_o(ph[1]), .cycle_count_o(cc[1]));

  instr_mem_stim_gen #(.MaxOutstanding(2), .RespLatency(5)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req[2]), .instr_addr_i(addr[2]),
    .instr_gnt_o(gnt[2]), .instr_rvalid_o(rv[2]), .instr_rdata_o(rd[2]),
    .instr_err_o(er[2]), .phase2_active_o(ph[2]), .cycle_count_o(cc[2]));

  instr_mem_stim_gen #(.StallMode(1), .MaxStall(3)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req[3]), .instr_addr_i(addr[3]),
    .instr_gnt_o(gnt[3]), .instr_rvalid_o(rv[3]), .instr_rdata_o(rd[3]),
    .instr_err_o(er[3]), .phase2_active_o(ph[3]), .cycle_count_o(cc[3]));

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] lf, input logic p2);
    if (!p2) return 32'h0000_0013;
    if (!lf[1]) return {lf[31:12], lf[11:7], 7'b0110111};
    return {lf[31:20], lf[19:15], 3'b000, lf[11:7], 7'b0010011};
  endfunction

  // Leaves the bench 1ns into cycle 0 with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    for (int i = 0; i < 4; i++) addr[i] = 32'h0000_0080;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    for (int i = 0; i < 4; i++) addr[i] = 32'h0000_0080;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (gnt[0] !== 1'b0) begin bad++; $display("FAIL rst_gnt0 got=%b exp=0", gnt[0]); end
    total++; if (gnt[3] !== 1'b0) begin bad++; $display("FAIL rst_gnt3 got=%b exp=0", gnt[3]); end
    total++; if (rv[0] !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", rv[0]); end
    total++; if (rd[0] !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rd[0]); end
    total++; if (er[0] !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", er[0]); end
    total++; if (ph[0] !== 1'b0) begin bad++; $display("FAIL rst_phase2 got=%b exp=0", ph[0]); end
    total++; if (cc[0] !== 32'h0) begin bad++; $display("FAIL rst_count got=%0d exp=0", cc[0]); end
  endtask

  task automatic test_nop_stream();
    do_reset();
    req[0] = 1'b1;
    for (int c = 0; c <= 101; c++) begin
      @(negedge clk);
      total++; if (gnt[0] !== 1'b1) begin bad++; $display("FAIL nop_gnt c=%0d got=%b exp=1", c, gnt[0]); end
      total++; if (cc[0] !== 32'(c)) begin bad++; $display("FAIL nop_count c=%0d got=%0d exp=%0d", c, cc[0], c); end
      total++; if (ph[0] !== (c >= 100)) begin bad++; $display("FAIL nop_phase2 c=%0d got=%b", c, ph[0]); end
      total++; if (rv[0] !== (c >= 1)) begin bad++; $display("FAIL nop_rvalid c=%0d got=%b", c, rv[0]); end
      if (c >= 1 && c <= 100) begin
        total++; if (rd[0] !== 32'h0000_0013) begin bad++; $display("FAIL nop_rdata c=%0d got=%h exp=00000013", c, rd[0]); end
        total++; if (er[0] !== 1'b0) begin bad++; $display("FAIL nop_err c=%0d got=%b exp=0", c, er[0]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_window();
    logic [31:0] a_tab [4];
    logic        e_tab [4];
    a_tab[0] = 32'h0001_0000; e_tab[0] = 1'b1;
    a_tab[1] = 32'h0000_FFFC; e_tab[1] = 1'b0;
    a_tab[2] = 32'h0001_0003; e_tab[2] = 1'b1;
    a_tab[3] = 32'h0000_0000; e_tab[3] = 1'b0;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      req[0] = (c < 4);
      if (c < 4) addr[0] = a_tab[c];
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        total++; if (rv[0] !== 1'b1) begin bad++; $display("FAIL win_rvalid c=%0d got=%b exp=1", c, rv[0]); end
        total++; if (er[0] !== e_tab[c-1]) begin bad++; $display("FAIL win_err c=%0d got=%b exp=%b", c, er[0], e_tab[c-1]); end
        total++; if (rd[0] !== (e_tab[c-1] ? 32'h0 : 32'h13)) begin bad++; $display("FAIL win_rdata c=%0d got=%h", c, rd[0]); end
      end else if (c == 5) begin
        total++; if (rv[0] !== 1'b0) begin bad++; $display("FAIL win_idle_rvalid got=%b exp=0", rv[0]); end
        total++; if (rd[0] !== 32'h0 || er[0] !== 1'b0) begin bad++; $display("FAIL win_idle_data got=%h/%b exp=0/0", rd[0], er[0]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_phase2();
    logic [31:0] lf;
    logic [31:0] prev;
    lf   = SEED;
    prev = 32'h0;
    do_reset();
    req[1] = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      total++; if (ph[1] !== (c >= 4)) begin bad++; $display("FAIL p2_phase c=%0d got=%b exp=%b", c, ph[1], (c >= 4)); end
      total++; if (gnt[1] !== 1'b1) begin bad++; $display("FAIL p2_gnt c=%0d got=%b exp=1", c, gnt[1]); end
      if (c >= 1) begin
        total++; if (rv[1] !== 1'b1) begin bad++; $display("FAIL p2_rvalid c=%0d got=%b exp=1", c, rv[1]); end
        total++; if (rd[1] !== prev) begin bad++; $display("FAIL p2_rdata c=%0d got=%h exp=%h", c, rd[1], prev); end
        if (c >= 5) begin
          total++;
          if (!(rd[1][6:0] == 7'h37 || (rd[1][6:0] == 7'h13 && rd[1][14:12] == 3'b000))) begin
            bad++; $display("FAIL p2_opcode c=%0d got=%h", c, rd[1]);
          end
        end
      end
      prev = exp_rdata(lf, c >= 4);
      lf   = lfsr_next(lf);
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] g_tab;
    logic [13:0] r_tab;
    // bit c is the expected value in cycle c
    g_tab = 14'b11_0000_1100_0011;
    r_tab = 14'b01_1000_0110_0000;
    do_reset();
    req[2] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      total++; if (gnt[2] !== g_tab[c]) begin bad++; $display("FAIL b2b_gnt c=%0d got=%b exp=%b", c, gnt[2], g_tab[c]); end
      total++; if (rv[2] !== r_tab[c]) begin bad++; $display("FAIL b2b_rvalid c=%0d got=%b exp=%b", c, rv[2], r_tab[c]); end
      if (r_tab[c]) begin
        total++; if (rd[2] !== 32'h13) begin bad++; $display("FAIL b2b_rdata c=%0d got=%h exp=00000013", c, rd[2]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    logic [31:0] lf;
    int          st;
    int          run;
    int          denied;
    logic        exp_g;
    lf     = SEED;
    st     = 0;
    run    = 0;
    denied = 0;
    do_reset();
    req[3] = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      exp_g = lf[0] || (st == 3);
      total++; if (gnt[3] !== exp_g) begin bad++; $display("FAIL stall_gnt c=%0d got=%b exp=%b", c, gnt[3], exp_g); end
      if (gnt[3] === 1'b1) run = 0; else begin run++; denied++; end
      total++; if (run > 3) begin bad++; $display("FAIL stall_run c=%0d got=%0d exp<=3", c, run); end
      st = exp_g ? 0 : st + 1;
      lf = lfsr_next(lf);
      next_cycle();
    end
    total++; if (denied == 0) begin bad++; $display("FAIL stall_denials got=0 exp>0"); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req[0] = 1'b1;
    req[2] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) req[2] = 1'b0;
      @(negedge clk);
      if (c < 2) begin
        total++; if (gnt[2] !== 1'b1) begin bad++; $display("FAIL mid_pre_gnt c=%0d got=%b exp=1", c, gnt[2]); end
      end
      next_cycle();
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (gnt[0] !== 1'b0) begin bad++; $display("FAIL mid_async_gnt got=%b exp=0", gnt[0]); end
    total++; if (cc[0] !== 32'h0) begin bad++; $display("FAIL mid_async_count got=%0d exp=0", cc[0]); end
    total++; if (cc[2] !== 32'h0) begin bad++; $display("FAIL mid_async_count2 got=%0d exp=0", cc[2]); end
    total++; if (rv[2] !== 1'b0 || rd[2] !== 32'h0) begin bad++; $display("FAIL mid_async_resp got=%b/%h exp=0/0", rv[2], rd[2]); end
    req[0] = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      req[2] = (c == 8);
      @(negedge clk);
      if (c == 8) begin
        total++; if (gnt[2] !== 1'b1) begin bad++; $display("FAIL mid_new_gnt got=%b exp=1", gnt[2]); end
      end
      total++; if (rv[2] !== (c == 13)) begin bad++; $display("FAIL mid_rvalid c=%0d got=%b exp=%b", c, rv[2], (c == 13)); end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_nop_stream();
    test_window();
    test_phase2();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
